// File: rtl/sram_req_sequencer_if.sv
// Host request, FSM command and read-response signals of the SRAM request
// sequencer. The slave modport is the sequencer's view; the master modport
// is the view of whatever drives requests and models the read/write FSMs.
interface sram_req_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_address;
    logic [15:0] req_data;

    logic        wr_start;
    logic [15:0] wr_address;
    logic [15:0] wr_data;
    logic        wr_done;

    logic        rd_start;
    logic [15:0] rd_address;
    logic        rd_done;
    logic [15:0] rd_data;

    logic        resp_valid;
    logic [15:0] resp_data;
    logic        busy;
    logic        err_timeout;

    modport slave (
        input  req_valid, req_write, req_address, req_data,
        input  wr_done, rd_done, rd_data,
        output req_ready, wr_start, wr_address, wr_data,
        output rd_start, rd_address, resp_valid, resp_data, busy, err_timeout
    );

    modport master (
        output req_valid, req_write, req_address, req_data,
        output wr_done, rd_done, rd_data,
        input  req_ready, wr_start, wr_address, wr_data,
        input  rd_start, rd_address, resp_valid, resp_data, busy, err_timeout
    );
endinterface

// File: rtl/sram_req_sequencer.sv
// SRAM request sequencer: buffers host read/write requests in a small FIFO
// and issues them one at a time to the write or read FSM, waiting for done
// before the next. Read data comes back on a one-cycle response strobe.
// Optional WAIT watchdog: define SRAM_SEQ_TIMEOUT_EN to build it.
//
// state  | meaning
// IDLE   | no command in flight; pops the FIFO head when one is queued
// ISSUE  | one-cycle start pulse to the FSM selected by the command type
// WAIT   | waiting for that FSM's done (or watchdog expiry when built)
module sram_req_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    sram_req_sequencer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 33;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [EW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            r_cmd_write;
    logic [15:0]     r_wr_address;
    logic [15:0]     r_wr_data;
    logic [15:0]     r_rd_address;
    logic            r_resp_valid;
    logic [15:0]     r_resp_data;

    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_done_cur;
    logic            w_expire;
    logic [EW-1:0]   w_head;

    // ready is forced low while reset is held so nothing is accepted then
    assign w_ready    = (r_count != CW'(DEPTH)) && !i_rst;
    assign w_push     = bus.req_valid && w_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_done_cur = r_cmd_write ? bus.wr_done : bus.rd_done;

`ifdef SRAM_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [TW-1:0]   r_wait_cnt;
    logic            r_err_timeout;

    assign w_expire = (r_state == S_WAIT) && (r_wait_cnt == TW'(TIMEOUT - 1));

    // WAIT cycle counter, restarted on every ISSUE so it counts from WAIT entry
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
        end
    end

    // abort pulse; a done arriving on the expiry cycle takes precedence
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_expire && !w_done_cur;
        end
    end

    assign bus.err_timeout = r_err_timeout;
`else
    logic w_unused_timeout;

    assign w_expire         = 1'b0;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign bus.err_timeout  = 1'b0;
`endif

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state and pop decision; done is only looked at in WAIT
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_cur || w_expire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset because the pointers are cleared
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.req_write, bus.req_address, bus.req_data};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel out
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // command registers, loaded only on pop so they hold through WAIT
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cmd_write  <= 1'b0;
            r_wr_address <= '0;
            r_wr_data    <= '0;
            r_rd_address <= '0;
        end else if (w_pop) begin
            r_cmd_write <= w_head[32];
            if (w_head[32]) begin
                r_wr_address <= w_head[31:16];
                r_wr_data    <= w_head[15:0];
            end else begin
                r_rd_address <= w_head[31:16];
            end
        end
    end

    // read response capture and one-cycle strobe
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            if ((r_state == S_WAIT) && !r_cmd_write && bus.rd_done) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= bus.rd_data;
            end
        end
    end

    // starts decode straight from state so an async reset drops them at once
    assign bus.wr_start   = (r_state == S_ISSUE) &&  r_cmd_write;
    assign bus.rd_start   = (r_state == S_ISSUE) && !r_cmd_write;
    assign bus.wr_address = r_wr_address;
    assign bus.wr_data    = r_wr_data;
    assign bus.rd_address = r_rd_address;
    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_sram_req_sequencer.sv
// Directed bench for sram_req_sequencer: single write, single read, a full
// FIFO burst with stalled FSMs, reset during WAIT, and the WAIT watchdog
// (or its absence, depending on SRAM_SEQ_TIMEOUT_EN).
module tb_sram_req_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sram_req_sequencer_if bus();

    sram_req_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total  = 0;
    int bad    = 0;
    int n_wr   = 0;
    int n_rd   = 0;
    int n_resp = 0;
    int n_both = 0;

    // pulse counters sampled on the active edge (pre-update values)
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.wr_start) n_wr++;
            if (bus.rd_start) n_rd++;
            if (bus.resp_valid) n_resp++;
            if (bus.wr_start && bus.rd_start) n_both++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic w, input logic [15:0] a, input logic [15:0] d);
        bus.req_valid   = 1'b1;
        bus.req_write   = w;
        bus.req_address = a;
        bus.req_data    = d;
    endtask

    task automatic idle_req();
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_address = '0;
        bus.req_data    = '0;
    endtask

    task automatic expect_issue(input string tag, input logic w, input logic [15:0] a,
                                input logic [15:0] d);
        chk({tag, "_wr_start"}, 32'(bus.wr_start), 32'(w));
        chk({tag, "_rd_start"}, 32'(bus.rd_start), 32'(!w));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        if (w) begin
            chk({tag, "_wr_address"}, 32'(bus.wr_address), 32'(a));
            chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'(d));
        end else begin
            chk({tag, "_rd_address"}, 32'(bus.rd_address), 32'(a));
        end
    endtask

    // completes the in-flight command with a one-cycle done
    task automatic serve(input string tag, input logic w, input logic [15:0] rdv);
        if (w) begin
            bus.wr_done = 1'b1;
        end else begin
            bus.rd_done = 1'b1;
            bus.rd_data = rdv;
        end
        tick();
        bus.wr_done = 1'b0;
        bus.rd_done = 1'b0;
        bus.rd_data = '0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_start_gap"}, 32'({bus.wr_start, bus.rd_start}), 32'd0);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'(!w));
        if (!w) chk({tag, "_resp_data"}, 32'(bus.resp_data), 32'(rdv));
    endtask

    initial begin
        logic [15:0] a3 [5];
        logic [15:0] d3 [5];
        logic [15:0] rv3 [5];
        logic        w3 [5];
        int s_wr, s_rd, s_resp;

        a3  = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014};
        d3  = '{16'h00A0, 16'h0000, 16'h00A2, 16'h0000, 16'h00A4};
        rv3 = '{16'h0000, 16'h5511, 16'h0000, 16'h5513, 16'h0000};
        w3  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        idle_req();
        bus.wr_done = 1'b0;
        bus.rd_done = 1'b0;
        bus.rd_data = '0;

        // reset state
        repeat (2) tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_starts", 32'({bus.wr_start, bus.rd_start}), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
        chk("rst_addrs", {bus.wr_address, bus.rd_address}, 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_err", 32'(bus.err_timeout), 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_req_ready", 32'(bus.req_ready), 32'd1);

        // single write, done 4 cycles after start
        s_wr = n_wr; s_resp = n_resp;
        drive_req(1'b1, 16'd100, 16'd10);
        tick();
        idle_req();
        chk("t1_no_bypass", 32'({bus.wr_start, bus.rd_start}), 32'd0);
        tick();
        expect_issue("t1_issue", 1'b1, 16'd100, 16'd10);
        tick();
        chk("t1_wait_start", 32'(bus.wr_start), 32'd0);
        tick();
        tick();
        chk("t1_hold_addr", 32'(bus.wr_address), 32'd100);
        chk("t1_hold_data", 32'(bus.wr_data), 32'd10);
        chk("t1_hold_busy", 32'(bus.busy), 32'd1);
        serve("t1_done", 1'b1, 16'h0);
        chk("t1_wr_pulses", 32'(n_wr - s_wr), 32'd1);
        chk("t1_no_resp", 32'(n_resp - s_resp), 32'd0);

        // single read; dones during ISSUE and the other type's done are ignored
        s_rd = n_rd; s_resp = n_resp;
        drive_req(1'b0, 16'h0042, 16'hFFFF);
        tick();
        idle_req();
        tick();
        expect_issue("t2_issue", 1'b0, 16'h0042, 16'h0);
        bus.rd_done = 1'b1;
        bus.rd_data = 16'h1111;
        tick();
        chk("t2_issue_done_ign", 32'(bus.busy), 32'd1);
        chk("t2_no_early_resp", 32'(bus.resp_valid), 32'd0);
        bus.rd_done = 1'b0;
        bus.rd_data = '0;
        bus.wr_done = 1'b1;
        tick();
        chk("t2_wr_done_ign", 32'(bus.busy), 32'd1);
        bus.wr_done = 1'b0;
        serve("t2_done", 1'b0, 16'hBEEF);
        tick();
        chk("t2_resp_one_cycle", 32'(bus.resp_valid), 32'd0);
        chk("t2_resp_held", 32'(bus.resp_data), 32'h0000BEEF);
        chk("t2_rd_pulses", 32'(n_rd - s_rd), 32'd1);
        chk("t2_resp_count", 32'(n_resp - s_resp), 32'd1);

        // five back-to-back pushes with a stalled FSM: fills the FIFO
        for (int i = 0; i < 5; i++) begin
            drive_req(w3[i], a3[i], d3[i]);
            chk($sformatf("t3_ready_%0d", i), 32'(bus.req_ready), 32'd1);
            tick();
            if (i == 1) expect_issue("t3_issue0", w3[0], a3[0], d3[0]);
        end
        chk("t3_full_ready", 32'(bus.req_ready), 32'd0);
        drive_req(1'b1, 16'h0099, 16'h0099);
        tick();
        idle_req();
        chk("t3_still_full", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            serve($sformatf("t3_done%0d", i), w3[i], rv3[i]);
            tick();
            if (i < 4) begin
                expect_issue($sformatf("t3_issue%0d", i + 1), w3[i + 1], a3[i + 1], d3[i + 1]);
                tick();
            end else begin
                chk("t3_drained_busy", 32'(bus.busy), 32'd0);
                chk("t3_drained_ready", 32'(bus.req_ready), 32'd1);
            end
        end

        // reset during WAIT of a write with two reads queued
        drive_req(1'b1, 16'h0020, 16'h0077);
        tick();
        drive_req(1'b0, 16'h0021, 16'h0);
        tick();
        drive_req(1'b0, 16'h0022, 16'h0);
        tick();
        idle_req();
        tick();
        chk("t4_in_wait", 32'(bus.busy), 32'd1);
        s_wr = n_wr; s_rd = n_rd; s_resp = n_resp;
        rst = 1'b1;
        drive_req(1'b0, 16'h0055, 16'h0);
        #1;
        chk("t4_starts_drop", 32'({bus.wr_start, bus.rd_start}), 32'd0);
        chk("t4_busy_drop", 32'(bus.busy), 32'd0);
        chk("t4_ready_in_rst", 32'(bus.req_ready), 32'd0);
        chk("t4_addr_clear", 32'(bus.wr_address), 32'd0);
        tick();
        tick();
        idle_req();
        rst = 1'b0;
        repeat (4) tick();
        chk("t4_idle_after", 32'(bus.busy), 32'd0);
        chk("t4_ready_after", 32'(bus.req_ready), 32'd1);
        chk("t4_no_starts", 32'((n_wr - s_wr) + (n_rd - s_rd)), 32'd0);
        chk("t4_no_resp", 32'(n_resp - s_resp), 32'd0);
        drive_req(1'b0, 16'h0030, 16'h0);
        tick();
        idle_req();
        tick();
        expect_issue("t4_new_issue", 1'b0, 16'h0030, 16'h0);
        tick();
        serve("t4_new_done", 1'b0, 16'h1234);

        // watchdog: write never completes, a read is queued behind it
        drive_req(1'b1, 16'h0040, 16'h0044);
        tick();
        drive_req(1'b0, 16'h0041, 16'h0);
        tick();
        idle_req();
        tick();
`ifdef SRAM_SEQ_TIMEOUT_EN
        repeat (15) tick();
        chk("t5_before_expiry_err", 32'(bus.err_timeout), 32'd0);
        chk("t5_before_expiry_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("t5_err_pulse", 32'(bus.err_timeout), 32'd1);
        chk("t5_back_idle", 32'(bus.busy), 32'd0);
        chk("t5_no_resp", 32'(bus.resp_valid), 32'd0);
        tick();
        chk("t5_err_one_cycle", 32'(bus.err_timeout), 32'd0);
        expect_issue("t5_next_issue", 1'b0, 16'h0041, 16'h0);
`else
        repeat (20) tick();
        chk("t5_stays_wait", 32'(bus.busy), 32'd1);
        chk("t5_no_err", 32'(bus.err_timeout), 32'd0);
        chk("t5_no_next_start", 32'(bus.rd_start), 32'd0);
        serve("t5_late_done", 1'b1, 16'h0);
        tick();
        expect_issue("t5_next_issue", 1'b0, 16'h0041, 16'h0);
`endif
        tick();
        serve("t5_read_done", 1'b0, 16'hCAFE);

        chk("onehot_starts", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
